// File: rtl/div16x8_seq.sv
// div16x8_seq: sequential restoring divider, 16-bit dividend / 8-bit divisor.
// Produces one quotient bit per clock and uses valid/ready handshakes on both sides.
// Optional feature macro: DIV_QUOT_OVF_EN.
//   When it is defined, quot_ovf flags quotients that do not fit in 8 bits.
//   When it is undefined, quot_ovf is tied to 0.

module div16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        quot_ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [15:0] r_q;      // dividend shifting out, quotient bits shifting in
  logic [7:0]  r_r;      // partial remainder
  logic [7:0]  r_div;
  logic [3:0]  r_cnt;
  logic [15:0] r_quot;
  logic [7:0]  r_rem;
  logic        r_dbz;

  logic        w_accept;
  logic        w_div_zero;
  logic        w_last;
  logic [8:0]  w_s;
  logic        w_ge;
  logic [7:0]  w_r_next;
  logic [15:0] w_q_next;

  assign w_accept   = in_valid & in_ready;
  assign w_div_zero = (divisor == 8'd0);
  assign w_last     = (r_cnt == 4'd15);

  // One restoring step.
  // The compare is 9 bits wide so that a carried-out bit in s[8] always forces a subtract.
  assign w_s      = {r_r, r_q[15]};
  assign w_ge     = (w_s >= {1'b0, r_div});
  assign w_r_next = w_ge ? 8'(w_s - {1'b0, r_div}) : w_s[7:0];
  assign w_q_next = {r_q[14:0], w_ge};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_next = w_div_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  // Datapath: operand load, iteration and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= 16'd0;
      r_r    <= 8'd0;
      r_div  <= 8'd0;
      r_cnt  <= 4'd0;
      r_quot <= 16'd0;
      r_rem  <= 8'd0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_div <= divisor;
            r_q   <= dividend;
            r_r   <= 8'd0;
            r_cnt <= 4'd0;
            if (w_div_zero) begin
              r_quot <= 16'hFFFF;
              r_rem  <= dividend[7:0];
              r_dbz  <= 1'b1;
            end
          end
        end
        StRun: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

`ifdef DIV_QUOT_OVF_EN
  logic r_ovf;

  // Overflow flag, captured alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == StIdle) && w_accept && w_div_zero) begin
      r_ovf <= 1'b1;
    end else if ((r_state == StRun) && w_last) begin
      r_ovf <= |w_q_next[15:8];
    end
  end

  assign quot_ovf = r_ovf;
`else
  assign quot_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_div16x8_seq.sv
// Self-checking bench for div16x8_seq.
// It runs directed cases, a backpressure case, a reset issued mid-operation,
// and a randomized stream, all checked against an arithmetic reference model.

module tb_div16x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        quot_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  div16x8_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .quot_ovf    (quot_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [15:0] q, input logic dz);
`ifdef DIV_QUOT_OVF_EN
    return dz | (q > 16'd255);
`else
    return 1'b0 & dz & q[0];
`endif
  endfunction

  // Issue one operation, check latency and result, apply backpressure for hold cycles, release.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int hold,
                       input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          edges;
    int          waitc;
    if (b == 8'd0) begin
      eq  = 16'hFFFF;
      er  = a[7:0];
      edz = 1'b1;
    end else begin
      eq  = a / 16'(b);
      er  = 8'(a % 16'(b));
      edz = 1'b0;
    end
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;  // accept edge
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    edges = 1;
    while (!out_valid && edges < 40) begin
      check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) begin
      check({tag, "_done_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(edges), (b == 8'd0) ? 32'd1 : 32'd17);
    check({tag, "_quot"}, 32'(quotient), 32'(eq));
    check({tag, "_rem"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    check({tag, "_ovf"}, 32'(quot_ovf), 32'(exp_ovf(eq, edz)));
    if (b != 8'd0) begin
      check({tag, "_identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, "_rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      dividend = 16'($urandom);
      divisor  = 8'd0;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_quot"}, 32'(quotient), 32'(eq));
      check({tag, "_hold_rem"}, 32'(remainder), 32'(er));
      check({tag, "_hold_dbz"}, 32'(div_by_zero), 32'(edz));
    end
    // Keep in_valid high across the release edge: it must not be accepted in the same cycle.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_quot_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quot", 32'(quotient), 32'd0);
    check("reset_rem", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_ovf", 32'(quot_ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(16'hFFFF, 8'hFF, 0, "ffff_ff");
    do_op(16'd1000, 8'd7, 0, "d1000_7");
    do_op(16'h0000, 8'h01, 0, "zero_1");
    do_op(16'h1234, 8'h00, 0, "divzero");
    do_op(16'h7D00, 8'h80, 10, "backpressure");

    // Reset in the middle of 0xABCD / 0x3C.
    in_valid = 1'b1;
    dividend = 16'hABCD;
    divisor  = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quot", 32'(quotient), 32'd0);
    check("midrst_rem", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    check("midrst_ovf", 32'(quot_ovf), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'h0064, 8'h0A, 0, "after_rst");

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      do_op(ra, rb, int'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
